// File: rtl/spi_ddr_pkg.sv
// rtl/spi_ddr_pkg.sv - shared types and helpers for the SPI DDR output serializer
package spi_ddr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STALL = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LW_X1  = 2'b00,
        LW_X2  = 2'b01,
        LW_X4  = 2'b10,
        LW_BAD = 2'b11
    } lane_width_e;

    function automatic int beats_per_word(input int width, input logic ddr, input int word_w);
        return word_w / (width * (ddr ? 2 : 1));
    endfunction

    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4);
    endfunction

    function automatic bit word_w_legal(input int word_w);
        return (word_w >= 8) && ((word_w % 8) == 0);
    endfunction

endpackage

// File: rtl/spi_ddr_serializer_if.sv
// rtl/spi_ddr_serializer_if.sv - word stream handshake into the SPI DDR serializer
interface spi_ddr_serializer_if #(
    parameter int WORD_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              s_last;
    logic [1:0]        lane_sel;
    logic              ddr;

    modport master (
        output s_valid, s_data, s_last, lane_sel, ddr,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_data, s_last, lane_sel, ddr,
        output s_ready
    );
endinterface

// File: rtl/spi_ddr_lane_map.sv
// rtl/spi_ddr_lane_map.sv - maps shift-register MSBs onto lanes for both half-cycles
module spi_ddr_lane_map #(
    parameter int LANES = 4
) (
    input  logic [2*LANES-1:0] msbs,
    input  logic [2:0]         width,
    input  logic               ddr,
    output logic [LANES-1:0]   q_p,
    output logic [LANES-1:0]   q_n,
    output logic [LANES-1:0]   oe
);
    localparam int IW = (2 * LANES > 2) ? $clog2(2 * LANES) : 1;

    logic [IW-1:0] idx_p;
    logic [IW-1:0] idx_n;

    // Lane i of a W-wide chunk takes bit (top - W + i), so lane W-1 gets the chunk MSB.
    always_comb begin
        q_p   = '0;
        q_n   = '0;
        oe    = '0;
        idx_p = '0;
        idx_n = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(width)) begin
                idx_p  = IW'(2 * LANES - int'(width) + i);
                idx_n  = IW'(2 * LANES - 2 * int'(width) + i);
                q_p[i] = msbs[idx_p];
                q_n[i] = ddr ? msbs[idx_n] : msbs[idx_p];
                oe[i]  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_ddr_serializer.sv
// rtl/spi_ddr_serializer.sv - multi-lane SDR/DDR SPI output serializer with underrun SCK stretch
module spi_ddr_serializer
    import spi_ddr_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int WORD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_ddr_serializer_if.slave  s,
    output logic [LANES-1:0]     q_p,
    output logic [LANES-1:0]     q_n,
    output logic [LANES-1:0]     oe,
    output logic                 sck_p,
    output logic                 sck_n,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);
    localparam int CNT_W = $clog2(WORD_W) + 1;
    localparam int MAP_W = 2 * LANES;

    generate
        if (!lanes_legal(LANES)) begin : g_bad_lanes
            $error("LANES must be 1, 2 or 4");
        end
        if (!word_w_legal(WORD_W)) begin : g_bad_word_w
            $error("WORD_W must be a non-zero multiple of 8");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        w_q, w_d;
    logic              ddr_q, ddr_d;
    logic              last_q, last_d;
    logic [LANES-1:0]  q_p_q, q_p_d, q_n_q, q_n_d, oe_q, oe_d;
    logic              sck_p_q, sck_p_d, sck_n_q, sck_n_d;
    logic              busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic              s_ready_q, s_ready_d;

    logic              load;
    logic [2:0]        dec_w;
    logic              dec_bad;
    logic [2:0]        map_w;
    logic              map_ddr;
    logic [WORD_W-1:0] map_src;
    logic [WORD_W-1:0] shifted;
    logic [3:0]        chunk_bits;
    logic [LANES-1:0]  map_qp, map_qn, map_oe;

    assign load = s.s_valid & s_ready_q;

    always_comb begin
        dec_bad = 1'b0;
        case (lane_width_e'(s.lane_sel))
            LW_X1:   dec_w = 3'd1;
            LW_X2:   dec_w = 3'd2;
            LW_X4:   dec_w = 3'd4;
            default: begin
                dec_w   = 3'd1;
                dec_bad = 1'b1;
            end
        endcase
        if (int'(dec_w) > LANES) begin
            dec_w   = 3'd1;
            dec_bad = 1'b1;
        end
    end

    // A freshly accepted word drives its first beat straight from s_data.
    always_comb begin
        map_w      = load ? dec_w : w_q;
        map_ddr    = load ? s.ddr : ddr_q;
        map_src    = load ? s.s_data : sh_q;
        chunk_bits = map_ddr ? {map_w, 1'b0} : {1'b0, map_w};
        shifted    = map_src << chunk_bits;
    end

    spi_ddr_lane_map #(
        .LANES (LANES)
    ) u_lane_map (
        .msbs  (map_src[WORD_W-1 -: MAP_W]),
        .width (map_w),
        .ddr   (map_ddr),
        .q_p   (map_qp),
        .q_n   (map_qn),
        .oe    (map_oe)
    );

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        ddr_d     = ddr_q;
        last_d    = last_q;
        q_p_d     = q_p_q;
        q_n_d     = q_n_q;
        oe_d      = oe_q;
        sck_p_d   = sck_p_q;
        sck_n_d   = sck_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cfg_err_d = cfg_err_q;

        if (load) begin
            state_d   = SHIFT;
            sh_d      = shifted;
            cnt_d     = CNT_W'(beats_per_word(int'(dec_w), s.ddr, WORD_W) - 1);
            w_d       = dec_w;
            ddr_d     = s.ddr;
            last_d    = s.s_last;
            q_p_d     = map_qp;
            q_n_d     = map_qn;
            oe_d      = map_oe;
            sck_p_d   = 1'b0;
            sck_n_d   = 1'b1;
            busy_d    = 1'b1;
            cfg_err_d = cfg_err_q | dec_bad;
        end else begin
            case (state_q)
                IDLE: ;
                SHIFT: begin
                    if (cnt_q != '0) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q - CNT_W'(1);
                        q_p_d = map_qp;
                        q_n_d = map_qn;
                        oe_d  = map_oe;
                    end else if (last_q) begin
                        state_d = IDLE;
                        q_p_d   = '0;
                        q_n_d   = '0;
                        oe_d    = '0;
                        sck_p_d = 1'b0;
                        sck_n_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Underrun: data and enables hold, SCK is parked low.
                        state_d = STALL;
                        sck_p_d = 1'b0;
                        sck_n_d = 1'b0;
                    end
                end
                STALL: ;
                default: state_d = IDLE;
            endcase
        end

        s_ready_d = (state_d != SHIFT) || ((cnt_d == '0) && !last_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            w_q       <= 3'd1;
            ddr_q     <= 1'b0;
            last_q    <= 1'b0;
            q_p_q     <= '0;
            q_n_q     <= '0;
            oe_q      <= '0;
            sck_p_q   <= 1'b0;
            sck_n_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            w_q       <= w_d;
            ddr_q     <= ddr_d;
            last_q    <= last_d;
            q_p_q     <= q_p_d;
            q_n_q     <= q_n_d;
            oe_q      <= oe_d;
            sck_p_q   <= sck_p_d;
            sck_n_q   <= sck_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s.s_ready = s_ready_q;
    assign q_p       = q_p_q;
    assign q_n       = q_n_q;
    assign oe        = oe_q;
    assign sck_p     = sck_p_q;
    assign sck_n     = sck_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_spi_ddr_serializer.sv
// tb/tb_spi_ddr_serializer.sv - scoreboard bench for the SPI DDR output serializer
module tb_spi_ddr_serializer;
    localparam int LANES  = 4;
    localparam int WORD_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_ddr_serializer_if #(.WORD_W(WORD_W)) sif ();

    logic [LANES-1:0] q_p, q_n, oe;
    logic             sck_p, sck_n, busy, done, cfg_err;

    spi_ddr_serializer #(
        .LANES  (LANES),
        .WORD_W (WORD_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s       (sif),
        .q_p     (q_p),
        .q_n     (q_n),
        .oe      (oe),
        .sck_p   (sck_p),
        .sck_n   (sck_n),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err)
    );

    typedef struct {
        logic [LANES-1:0] qp;
        logic [LANES-1:0] qn;
        logic [LANES-1:0] oe;
        bit               first;
        bit               burst_end;
        int               acc;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    edge_n = 0;
    int    stall_n = 0;
    bit    exp_cfg_err = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every SCK-active cycle consumes one expected beat.
    bit               pend_done = 1'b0;
    logic [LANES-1:0] last_qp, last_qn, last_oe;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_done = 1'b0;
        end else begin
            if (pend_done) begin
                chk("done_cycle", {done, busy, sck_p, sck_n, q_p, q_n, oe}, {1'b1, 1'b0, 2'b00, {(3*LANES){1'b0}}});
                chk("cfg_err_at_done", cfg_err, exp_cfg_err);
                pend_done = 1'b0;
            end else if (done) begin
                chk("spurious_done", done, 1'b0);
            end
            if (sck_n) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("q_p", q_p, e.qp);
                    chk("q_n", q_n, e.qn);
                    chk("oe", oe, e.oe);
                    chk("beat_sck_busy", {sck_p, busy}, 2'b01);
                    if (e.first) chk("first_beat_latency", edge_n, e.acc);
                    pend_done = e.burst_end;
                    last_qp = q_p;
                    last_qn = q_n;
                    last_oe = oe;
                end
            end else if (busy) begin
                stall_n++;
                chk("stall_hold", {sck_p, q_p, q_n, oe, sif.s_ready}, {1'b0, last_qp, last_qn, last_oe, 1'b1});
            end
        end
    end

    task automatic send(input logic [WORD_W-1:0] data, input logic [1:0] sel,
                        input logic d, input logic last, input int gap);
        int    raw, w, c, nb, sh, mask, bound;
        bit    bad;
        beat_t b;
        sif.s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        sif.s_valid  = 1'b1;
        sif.s_data   = data;
        sif.lane_sel = sel;
        sif.ddr      = d;
        sif.s_last   = last;
        bound = 0;
        while (!sif.s_ready && bound < 100) begin
            @(posedge clk); #1;
            bound++;
        end
        chk("accept_ready", sif.s_ready, 1'b1);
        if (!sif.s_ready) begin
            sif.s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        sif.s_valid = 1'b0;
        raw  = (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : (sel == 2'b10) ? 4 : 0;
        bad  = (raw == 0) || (raw > LANES);
        w    = bad ? 1 : raw;
        c    = d ? 2 * w : w;
        nb   = WORD_W / c;
        mask = (1 << w) - 1;
        for (int k = 0; k < nb; k++) begin
            sh          = WORD_W - k * c - w;
            b.qp        = LANES'((int'(data) >> sh) & mask);
            b.qn        = d ? LANES'((int'(data) >> (sh - w)) & mask) : b.qp;
            b.oe        = LANES'(mask);
            b.first     = (k == 0);
            b.burst_end = last && (k == nb - 1);
            b.acc       = edge_n;
            exp_q.push_back(b);
        end
        if (bad) exp_cfg_err = 1'b1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", (exp_q.size() == 0) && !busy, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int s0;
        sif.s_valid  = 1'b0;
        sif.s_data   = '0;
        sif.s_last   = 1'b0;
        sif.lane_sel = 2'b00;
        sif.ddr      = 1'b0;

        #12;
        chk("reset_outputs", {q_p, q_n, oe, sck_p, sck_n, busy, done, cfg_err}, '0);
        chk("reset_ready", sif.s_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ready_before_clk", sif.s_ready, 1'b0);
        @(posedge clk); #1;
        chk("ready_after_clk", sif.s_ready, 1'b1);

        send(8'hA5, 2'b00, 1'b0, 1'b1, 0);
        wait_idle();
        send(8'hA5, 2'b10, 1'b1, 1'b1, 0);
        wait_idle();

        s0 = stall_n;
        send(8'h3C, 2'b01, 1'b0, 1'b0, 0);
        send(8'h81, 2'b01, 1'b0, 1'b1, 0);
        wait_idle();
        chk("b2b_no_gap", stall_n - s0, 0);

        s0 = stall_n;
        send(8'hF0, 2'b10, 1'b0, 1'b0, 0);
        send(8'h0F, 2'b10, 1'b0, 1'b1, 4);
        wait_idle();
        chk("underrun_stall_cycles", stall_n - s0, 3);

        send(8'h80, 2'b11, 1'b0, 1'b1, 0);
        wait_idle();
        chk("cfg_err_sticky", cfg_err, 1'b1);

        send(8'hA5, 2'b00, 1'b0, 1'b1, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_cfg_err = 1'b0;
        chk("midword_reset_outputs", {q_p, q_n, oe, sck_p, sck_n, busy, done, cfg_err, sif.s_ready}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ready_after_release", sif.s_ready, 1'b0);
        @(posedge clk); #1;
        chk("ready_one_clk_later", sif.s_ready, 1'b1);
        repeat (3) begin @(posedge clk); #1; end

        for (int i = 0; i < 40; i++) begin
            logic [1:0] sel;
            logic       d, last;
            int         gap;
            sel  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            d    = 1'($urandom_range(0, 1));
            last = (i == 39) || ($urandom_range(0, 2) == 0);
            gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            send(8'($urandom), sel, d, last, gap);
        end
        wait_idle();
        repeat (2) begin @(posedge clk); #1; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
